// File: rtl/ysyx_23060124_exu_pipe.sv
// ysyx_23060124_exu_pipe: registered execute stage with ALU, branch compare and valid/ready on both sides.
// Define YSYX_23060124_MDU_EN to build the iterative RV32M multiply/divide unit (CALC state, o_busy).
module ysyx_23060124_exu_pipe #(
    parameter int XLEN     = 32,
    parameter int RD_WIDTH = 5
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_pre_valid,
    output logic                o_pre_ready,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     i_pc,
    input  logic [1:0]          i_src_sel,
    input  logic [3:0]          exu_opt,
    input  logic [3:0]          mdu_opt,
    input  logic [2:0]          brch_opt,
    input  logic [RD_WIDTH-1:0] i_rd,
    output logic                o_post_valid,
    input  logic                i_post_ready,
    output logic [XLEN-1:0]     o_res,
    output logic [RD_WIDTH-1:0] o_rd,
    output logic                o_brch_taken,
    output logic                o_busy
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] { IDLE, CALC, HOLD } state_t;

    state_t          state;
    logic            accept;
    logic            brch_taken;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;

    assign o_pre_ready  = (state == IDLE) | ((state == HOLD) & i_post_ready);
    assign o_post_valid = (state == HOLD);
    assign accept       = i_pre_valid & o_pre_ready;
    assign shamt        = op_b[SHW-1:0];

    always_comb begin
        op_a = src1;
        op_b = src2;
        case (i_src_sel)
            2'd1: op_b = imm;
            2'd2: begin op_a = i_pc; op_b = XLEN'(4); end
            2'd3: begin op_a = i_pc; op_b = imm; end
            default: ;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (exu_opt)
            4'd0: alu_res = op_a + op_b;
            4'd1: alu_res = op_a - op_b;
            4'd2: alu_res = op_a << shamt;
            4'd3: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd4: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'd5: alu_res = op_a ^ op_b;
            4'd6: alu_res = op_a >> shamt;
            4'd7: alu_res = $unsigned($signed(op_a) >>> shamt);
            4'd8: alu_res = op_a | op_b;
            4'd9: alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
    end

    // Branches always compare the raw register operands, independent of i_src_sel.
    always_comb begin
        brch_taken = 1'b0;
        case (brch_opt)
            3'd1: brch_taken = (src1 == src2);
            3'd2: brch_taken = (src1 != src2);
            3'd3: brch_taken = ($signed(src1) <  $signed(src2));
            3'd4: brch_taken = ($signed(src1) >= $signed(src2));
            3'd5: brch_taken = (src1 <  src2);
            3'd6: brch_taken = (src1 >= src2);
            default: ;
        endcase
    end

`ifdef YSYX_23060124_MDU_EN
    localparam logic [3:0] MD_MUL    = 4'd1;
    localparam logic [3:0] MD_MULH   = 4'd2;
    localparam logic [3:0] MD_MULHSU = 4'd3;
    localparam logic [3:0] MD_MULHU  = 4'd4;
    localparam logic [3:0] MD_DIV    = 4'd5;
    localparam logic [3:0] MD_DIVU   = 4'd6;
    localparam logic [3:0] MD_REM    = 4'd7;
    localparam logic [3:0] MD_REMU   = 4'd8;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic              is_mdu, is_mul, a_signed, b_signed, a_neg, b_neg;
    logic              start_neg, div_zero, div_ovf, div_ge;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;
    logic [XLEN-1:0]   md_hi, md_lo, md_opnd;
    logic [3:0]        md_op;
    logic              md_neg;
    logic [SHW-1:0]    md_cnt;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   step_hi, step_lo, quot_c, rem_c, md_final;
    logic [2*XLEN-1:0] prod, prod_c;

    // Codes 9..15 are not RV32M ops and fall through to the ALU.
    always_comb begin
        is_mdu    = (mdu_opt != 4'd0) && (mdu_opt <= MD_REMU);
        is_mul    = (mdu_opt <= MD_MULHU);
        a_signed  = (mdu_opt == MD_MULH) || (mdu_opt == MD_MULHSU) ||
                    (mdu_opt == MD_DIV)  || (mdu_opt == MD_REM);
        b_signed  = (mdu_opt == MD_MULH) || (mdu_opt == MD_DIV) || (mdu_opt == MD_REM);
        a_neg     = a_signed & op_a[XLEN-1];
        b_neg     = b_signed & op_b[XLEN-1];
        a_mag     = a_neg ? -op_a : op_a;
        b_mag     = b_neg ? -op_b : op_b;
        start_neg = (mdu_opt == MD_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero  = !is_mul && (op_b == '0);
        div_ovf   = ((mdu_opt == MD_DIV) || (mdu_opt == MD_REM)) && (op_a == XMIN) && (op_b == '1);
        special_res = '0;
        if (div_zero)
            special_res = ((mdu_opt == MD_DIV) || (mdu_opt == MD_DIVU)) ? '1 : op_a;
        else if (div_ovf)
            special_res = (mdu_opt == MD_DIV) ? XMIN : '0;
    end

    // md_hi/md_lo hold {partial product, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_opnd} : '0);
        div_shift = {md_hi, md_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, md_opnd};
        div_ge    = ~div_diff[XLEN];
        if (md_op <= MD_MULHU) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], md_lo[XLEN-1:1]};
        end else begin
            step_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {md_lo[XLEN-2:0], div_ge};
        end
        prod   = {step_hi, step_lo};
        prod_c = md_neg ? -prod : prod;
        quot_c = md_neg ? -step_lo : step_lo;
        rem_c  = md_neg ? -step_hi : step_hi;
        case (md_op)
            MD_MUL:                        md_final = prod_c[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  md_final = prod_c[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               md_final = quot_c;
            MD_REM, MD_REMU:               md_final = rem_c;
            default:                       md_final = '0;
        endcase
    end

    assign o_busy = (state == CALC);
`else
    logic unused_mdu_opt;

    assign unused_mdu_opt = ^mdu_opt;
    assign o_busy         = 1'b0;
`endif

    // Output registers only change on accept or on the last MDU step, so HOLD keeps them stable.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_res        <= '0;
            o_rd         <= '0;
            o_brch_taken <= 1'b0;
`ifdef YSYX_23060124_MDU_EN
            md_hi   <= '0;
            md_lo   <= '0;
            md_opnd <= '0;
            md_op   <= '0;
            md_neg  <= 1'b0;
            md_cnt  <= '0;
`endif
        end else if (accept) begin
            o_rd <= i_rd;
`ifdef YSYX_23060124_MDU_EN
            if (is_mdu) begin
                o_brch_taken <= 1'b0;
                if (div_zero || div_ovf) begin
                    o_res <= special_res;
                    state <= HOLD;
                end else begin
                    md_op   <= mdu_opt;
                    md_neg  <= start_neg;
                    md_cnt  <= '0;
                    md_hi   <= '0;
                    md_lo   <= is_mul ? b_mag : a_mag;
                    md_opnd <= is_mul ? a_mag : b_mag;
                    state   <= CALC;
                end
            end else begin
                o_res        <= alu_res;
                o_brch_taken <= brch_taken;
                state        <= HOLD;
            end
`else
            o_res        <= alu_res;
            o_brch_taken <= brch_taken;
            state        <= HOLD;
`endif
        end else if ((state == HOLD) && i_post_ready) begin
            state <= IDLE;
        end
`ifdef YSYX_23060124_MDU_EN
        else if (state == CALC) begin
            md_hi  <= step_hi;
            md_lo  <= step_lo;
            md_cnt <= md_cnt + SHW'(1);
            if (md_cnt == SHW'(XLEN-1)) begin
                o_res <= md_final;
                state <= HOLD;
            end
        end
`endif
    end

endmodule

// File: doc/ysyx_23060124_exu_pipe.md
# ysyx_23060124_exu_pipe

Parametrised, registered execute stage for the ysyx_23060124 core, sitting between IDU and WBU/LSU. Performs single-cycle ALU ops, branch comparison and multi-cycle RV32M multiply/divide (iterative), with full valid/ready backpressure on both sides. Replaces the always-ready, combinational execute path with a pipeline register and a stall-capable MDU.

## Interface
- XLEN, 32: datapath width (≥8, power of 2)
- RD_WIDTH, 5: destination register index width
- clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_pre_valid  in  1  IDU has an op
- o_pre_ready  out  1  stage accepts op this cycle
- src1, src2, imm, i_pc  in  XLEN  operands
- i_src_sel  in  2  0 REG(src1,src2) 1 IMM(src1,imm) 2 PC4(i_pc,4) 3 PCI(i_pc,imm)
- exu_opt  in  4  0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND; others → result 0
- mdu_opt  in  4  0 none 1 MUL 2 MULH 3 MULHSU 4 MULHU 5 DIV 6 DIVU 7 REM 8 REMU; nonzero overrides exu_opt
- brch_opt  in  3  0 none 1 BEQ 2 BNE 3 BLT 4 BGE 5 BLTU 6 BGEU; compares src1 vs src2
- i_rd  in  RD_WIDTH  destination index
- o_post_valid  out  1  result register valid
- i_post_ready  in  1  WBU consumes
- o_res  out  XLEN  result
- o_rd  out  RD_WIDTH  registered i_rd
- o_brch_taken  out  1  registered branch outcome
- o_busy  out  1  MDU iterating

## Operation
- Handshake: transfer when valid&ready on the same edge. o_pre_ready = (state==IDLE) | (state==HOLD & i_post_ready).
- States: IDLE (output empty), CALC (MDU iterating), HOLD (output valid, waiting).
- Accept of ALU/branch op: o_res, o_rd, o_brch_taken registered → HOLD.
- Accept of MDU op: operands latched, counter=0 → CALC. Special cases skip CALC and go straight to HOLD: divide by zero (DIV/DIVU quotient all ones, REM/REMU = dividend); signed overflow DIV min/-1 → min, REM → 0.
- CALC: one shift-add (mul) or restoring subtract (div) step per cycle on magnitudes, XLEN steps; final cycle applies sign correction and writes o_res → HOLD.
- MUL returns low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of 2·XLEN product.
- Shift amount = low log2(XLEN) bits of operand 2. SLT/SLTU produce 0/1 zero-extended.
- HOLD & i_post_ready & !i_pre_valid → IDLE, o_post_valid drops next cycle. HOLD with i_post_ready low: all outputs stable.
- Branch: o_res still carries ALU result (PCI gives target); o_brch_taken=0 when brch_opt=0.
- CALC ignores i_pre_valid (o_pre_ready=0); i_post_ready irrelevant.

## Timing
- Reset (async assert, sync-released use): state IDLE, o_post_valid 0, o_res 0, o_rd 0, o_brch_taken 0, o_busy 0, o_pre_ready 1. Reset during CALC aborts operation, no result emitted.
- ALU/branch latency: 1 edge accept→o_post_valid. Back-to-back throughput 1/cycle with i_post_ready held high.
- MDU latency: XLEN+1 edges accept→o_post_valid (33 for XLEN=32); o_busy high for XLEN cycles exactly. Special cases: 1 edge.
- Simultaneous consume and accept in HOLD: new result replaces old with no bubble (ALU) or o_post_valid falls while CALC (MDU).

## Configuration
- YSYX_23060124_MDU_EN defined: MDU logic, CALC state and o_busy behaviour as above.
- Undefined: no MDU hardware; mdu_opt ignored (treated as 0, exu_opt executes), o_busy tied 0, CALC unreachable; o_pre_ready reduces to !o_post_valid | i_post_ready.

## Test plan
- Reset mid-CALC of DIVU 100/7 at cycle 10 → all outputs 0, o_pre_ready 1, no o_post_valid after release.
- ADD src1=5,imm=-3 (IMM), then SRA 0x80000000>>4 back-to-back, i_post_ready=1 → o_res 2 then 0xF8000000 on consecutive cycles.
- MULH 0xFFFFFFFF×0xFFFFFFFF → o_res 0 after 33 edges; MULHU same operands → 0xFFFFFFFE; o_busy high 32 cycles.
- DIV −7/2 → −3, REM −7/2 → −1; DIV 0x80000000/−1 → 0x80000000 after 1 edge; DIVU 9/0 → 0xFFFFFFFF after 1 edge.
- BLTU 1 vs 0xFFFFFFFF with PCI pc=0x80000000 imm=0x10 → o_brch_taken 1, o_res 0x80000010; BLT same → 0.
- Hold i_post_ready=0 for 5 cycles in HOLD → o_res/o_rd stable, o_pre_ready 0, pending IDU op accepted the edge i_post_ready rises.
